// File: rtl/bus_window_timeout_pkg.sv
// ============================================================================
// Module : bus_window_timeout_pkg
// Brief  : Bus field layout, status-register constants and FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_window_timeout_pkg;

    // Request-direction bus layout (upstream in, sub-bus out)
    localparam int BI_DATA_LSB   = 0;
    localparam int BI_ADDR_LSB   = 32;
    localparam int BI_RD_WR_L    = 64;
    localparam int BI_REQ        = 65;
    localparam int BI_STARTUP    = 66;
    localparam int BI_RESET_L    = 67;
    localparam int BI_CLK        = 68;
    localparam int BUS_IN_WIDTH  = 69;

    // Response-direction bus layout
    localparam int BO_DATA_LSB   = 0;
    localparam int BO_ACK        = 32;
    localparam int BO_IRQ        = 33;
    localparam int BUS_OUT_WIDTH = 34;

    localparam int BUS_DATA_W    = 32;
    localparam int BUS_ADDR_W    = 32;

    // Status register offsets and control bit positions
    localparam logic [31:0] STAT_OFS_STATUS = 32'd0;
    localparam logic [31:0] STAT_OFS_LAST   = 32'd4;
    localparam int STAT_BIT_TO      = 0;
    localparam int STAT_BIT_PROTO   = 1;
    localparam int STAT_BIT_CNT_CLR = 16;

    localparam int WAIT_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_window_timeout_timer.sv
// ============================================================================
// Module : bus_window_timer
// Brief  : Wait counter for an outstanding sub-bus request; flags the deadline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_window_timer
    import bus_window_timeout_pkg::*;
#(
    parameter int TIMEOUT = 1024
)(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] cnt;
    logic                  running;

    // Count reads 0 in the cycle after start, so it equals k k cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
        end else if (stop) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (running && (cnt != {WAIT_CNT_W{1'b1}})) begin
            cnt <= cnt + WAIT_CNT_W'(1);
        end
    end

    assign expired = running && (cnt == WAIT_CNT_W'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/bus_window_timeout.sv
// ============================================================================
// Module : bus_window_timeout
// Brief  : Forwards an address window to a sub-bus, acking on its behalf on timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_window_timeout
    import bus_window_timeout_pkg::*;
#(
    parameter logic [31:0] ADDR         = 32'h0,
    parameter int          ADDRWIDTH    = 8,
    parameter logic [31:0] STAT_ADDR    = 32'h100,
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
    parameter int          CNTWIDTH     = 16
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUS_IN_WIDTH-1:0]  bus_in,
    output logic [BUS_OUT_WIDTH-1:0] bus_out,
    output logic [BUS_IN_WIDTH-1:0]  sub_bus_in,
    input  logic [BUS_OUT_WIDTH-1:0] sub_bus_out
);

    localparam logic [31:0] WIN_MASK = ~((32'd1 << ADDRWIDTH) - 32'd1);

    logic        req;
    logic        rd_wr_l;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sub_ack;
    logic [31:0] sub_rdata;
    logic        sub_irq;

    assign req       = bus_in[BI_REQ];
    assign rd_wr_l   = bus_in[BI_RD_WR_L];
    assign addr      = bus_in[BI_ADDR_LSB +: BUS_ADDR_W];
    assign wdata     = bus_in[BI_DATA_LSB +: BUS_DATA_W];
    assign sub_ack   = sub_bus_out[BO_ACK];
    assign sub_rdata = sub_bus_out[BO_DATA_LSB +: BUS_DATA_W];
    assign sub_irq   = sub_bus_out[BO_IRQ];

    logic unused_bus_in;
    assign unused_bus_in = bus_in[BI_CLK] ^ bus_in[BI_RESET_L];

    logic        win_hit;
    logic        stat0_hit;
    logic        stat1_hit;
    logic        stat_hit;
    logic [31:0] sub_addr;

    assign win_hit   = req && ((addr & WIN_MASK) == (ADDR & WIN_MASK));
    assign stat0_hit = req && (addr == STAT_ADDR + STAT_OFS_STATUS);
    assign stat1_hit = req && (addr == STAT_ADDR + STAT_OFS_LAST);
    assign stat_hit  = stat0_hit || stat1_hit;
    assign sub_addr  = (ADDR & WIN_MASK) | (addr & ~WIN_MASK);

    state_t state;
    state_t state_nxt;
    logic   do_start;
    logic   do_sub_ack;
    logic   do_timeout;
    logic   do_stat;
    logic   do_proto;
    logic   expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A sub ack wins over an expiry in the same cycle.
    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        do_sub_ack = 1'b0;
        do_timeout = 1'b0;
        do_stat    = 1'b0;
        do_proto   = 1'b0;
        if (state == ST_IDLE) begin
            if (win_hit) begin
                do_start  = 1'b1;
                state_nxt = ST_BUSY;
            end else if (stat_hit) begin
                do_stat = 1'b1;
            end
        end else begin
            do_proto = win_hit || stat_hit;
            if (sub_ack) begin
                do_sub_ack = 1'b1;
                state_nxt  = ST_IDLE;
            end else if (expired) begin
                do_timeout = 1'b1;
                state_nxt  = ST_IDLE;
            end
        end
    end

    bus_window_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (do_start),
        .stop    (do_sub_ack || do_timeout),
        .expired (expired)
    );

    logic                sub_req_r;
    logic                sub_rd_r;
    logic [31:0]         sub_addr_r;
    logic [31:0]         sub_data_r;
    logic                cap_rd;
    logic [31:0]         cap_addr;
    logic                ack_r;
    logic [31:0]         data_r;
    logic [CNTWIDTH-1:0] timeout_cnt;
    logic [31:0]         last_addr;
    logic                flag_to;
    logic                flag_proto;
    logic [31:0]         status_word;

    assign status_word = {16'(timeout_cnt), 14'b0, flag_proto, flag_to};

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_req_r   <= 1'b0;
            sub_rd_r    <= 1'b0;
            sub_addr_r  <= '0;
            sub_data_r  <= '0;
            cap_rd      <= 1'b0;
            cap_addr    <= '0;
            ack_r       <= 1'b0;
            data_r      <= '0;
            timeout_cnt <= '0;
            last_addr   <= '0;
            flag_to     <= 1'b0;
            flag_proto  <= 1'b0;
        end else begin
            sub_req_r  <= 1'b0;
            sub_rd_r   <= 1'b0;
            sub_addr_r <= '0;
            sub_data_r <= '0;
            ack_r      <= 1'b0;
            data_r     <= '0;
            if (do_start) begin
                sub_req_r  <= 1'b1;
                sub_rd_r   <= rd_wr_l;
                sub_addr_r <= sub_addr;
                sub_data_r <= wdata;
                cap_rd     <= rd_wr_l;
                cap_addr   <= sub_addr;
            end
            if (do_sub_ack) begin
                ack_r  <= 1'b1;
                data_r <= sub_rdata;
            end
            if (do_timeout) begin
                ack_r     <= 1'b1;
                data_r    <= cap_rd ? TIMEOUT_DATA : 32'h0;
                last_addr <= cap_addr;
                flag_to   <= 1'b1;
                if (timeout_cnt != {CNTWIDTH{1'b1}}) begin
                    timeout_cnt <= timeout_cnt + CNTWIDTH'(1);
                end
            end
            if (do_proto) begin
                flag_proto <= 1'b1;
            end
            if (do_stat) begin
                ack_r <= 1'b1;
                if (rd_wr_l) begin
                    data_r <= stat0_hit ? status_word : last_addr;
                end else if (stat0_hit) begin
                    if (wdata[STAT_BIT_TO])      flag_to     <= 1'b0;
                    if (wdata[STAT_BIT_PROTO])   flag_proto  <= 1'b0;
                    if (wdata[STAT_BIT_CNT_CLR]) timeout_cnt <= '0;
                end
            end
        end
    end

    always_comb begin
        sub_bus_in                                = '0;
        sub_bus_in[BI_CLK]                        = clk;
        sub_bus_in[BI_RESET_L]                    = ~reset;
        sub_bus_in[BI_STARTUP]                    = bus_in[BI_STARTUP];
        sub_bus_in[BI_REQ]                        = sub_req_r;
        sub_bus_in[BI_RD_WR_L]                    = sub_rd_r;
        sub_bus_in[BI_ADDR_LSB +: BUS_ADDR_W]     = sub_addr_r;
        sub_bus_in[BI_DATA_LSB +: BUS_DATA_W]     = sub_data_r;
    end

    // Sub IRQ shares this clock, so it is merged without synchronisation.
    always_comb begin
        bus_out                               = '0;
        bus_out[BO_ACK]                       = ack_r;
        bus_out[BO_DATA_LSB +: BUS_DATA_W]    = data_r;
        bus_out[BO_IRQ]                       = flag_to || flag_proto || sub_irq;
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_window_timeout.sv
// ============================================================================
// Module : tb_bus_window_timeout
// Brief  : Directed, table-driven self-checking bench for bus_window_timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_window_timeout;
    import bus_window_timeout_pkg::*;

    localparam logic [31:0] STAT = 32'h0000_0100;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        up_req     = 1'b0;
    logic        up_rd      = 1'b0;
    logic        up_startup = 1'b0;
    logic [31:0] up_addr    = 32'h0;
    logic [31:0] up_wdata   = 32'h0;
    logic        sub_ack    = 1'b0;
    logic        sub_irq    = 1'b0;
    logic [31:0] sub_rdata  = 32'h0;

    logic [BUS_IN_WIDTH-1:0]  bus_in;
    logic [BUS_IN_WIDTH-1:0]  sub_bus_in;
    logic [BUS_OUT_WIDTH-1:0] bus_out;
    logic [BUS_OUT_WIDTH-1:0] sub_bus_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        bus_in                     = '0;
        bus_in[BI_CLK]             = clk;
        bus_in[BI_RESET_L]         = ~reset;
        bus_in[BI_STARTUP]         = up_startup;
        bus_in[BI_REQ]             = up_req;
        bus_in[BI_RD_WR_L]         = up_rd;
        bus_in[BI_ADDR_LSB +: 32]  = up_addr;
        bus_in[BI_DATA_LSB +: 32]  = up_wdata;
        sub_bus_out                = '0;
        sub_bus_out[BO_ACK]        = sub_ack;
        sub_bus_out[BO_IRQ]        = sub_irq;
        sub_bus_out[BO_DATA_LSB +: 32] = sub_rdata;
    end

    logic        ack_o, irq_o, sub_req_o, sub_rd_o, sub_rstl_o, sub_start_o;
    logic [31:0] data_o, sub_addr_o, sub_data_o;
    assign ack_o       = bus_out[BO_ACK];
    assign irq_o       = bus_out[BO_IRQ];
    assign data_o      = bus_out[BO_DATA_LSB +: 32];
    assign sub_req_o   = sub_bus_in[BI_REQ];
    assign sub_rd_o    = sub_bus_in[BI_RD_WR_L];
    assign sub_rstl_o  = sub_bus_in[BI_RESET_L];
    assign sub_start_o = sub_bus_in[BI_STARTUP];
    assign sub_addr_o  = sub_bus_in[BI_ADDR_LSB +: 32];
    assign sub_data_o  = sub_bus_in[BI_DATA_LSB +: 32];

    bus_window_timeout #(
        .ADDR         (32'h0000_2000),
        .ADDRWIDTH    (8),
        .STAT_ADDR    (STAT),
        .TIMEOUT      (16),
        .TIMEOUT_DATA (32'hDEAD_BEEF),
        .CNTWIDTH     (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_in      (bus_in),
        .bus_out     (bus_out),
        .sub_bus_in  (sub_bus_in),
        .sub_bus_out (sub_bus_out)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_data;
    } stat_vec_t;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;
        logic [31:0] rdata;
        logic [31:0] exp_sub_addr;
        logic [31:0] exp_data;
        int          exp_lat;
    } win_vec_t;

    stat_vec_t svec [8];
    win_vec_t  wvec [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle upstream request; returns the response seen the next cycle.
    task automatic single(input logic rd, input logic [31:0] a, input logic [31:0] d,
                          output logic ack, output logic [31:0] data);
        up_req = 1'b1; up_rd = rd; up_addr = a; up_wdata = d;
        tick();
        up_req = 1'b0; up_rd = 1'b0; up_addr = 32'h0; up_wdata = 32'h0;
        ack  = ack_o;
        data = data_o;
    endtask

    // Window access; sub ack driven ack_at cycles after the sub REQ (negative: never).
    task automatic window_txn(input string name, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input int ack_at, input logic [31:0] rdata,
                              input logic [31:0] exp_sub_addr, output int lat,
                              output logic [31:0] data);
        up_req = 1'b1; up_rd = rd; up_addr = a; up_wdata = d;
        tick();
        up_req = 1'b0; up_rd = 1'b0; up_addr = 32'h0; up_wdata = 32'h0;
        check({name, "_sub_req"},  32'(sub_req_o), 32'h1);
        check({name, "_sub_rd"},   32'(sub_rd_o), 32'(rd));
        check({name, "_sub_addr"}, sub_addr_o, exp_sub_addr);
        check({name, "_sub_data"}, sub_data_o, d);
        lat  = -1;
        data = 32'h0;
        for (int k = 0; k < 64 && lat < 0; k++) begin
            sub_ack   = (k == ack_at);
            sub_rdata = (k == ack_at) ? rdata : 32'h0;
            tick();
            sub_ack   = 1'b0;
            sub_rdata = 32'h0;
            if (k == 0) begin
                check({name, "_sub_req_pulse"}, 32'(sub_req_o), 32'h0);
                check({name, "_sub_addr_idle"}, sub_addr_o, 32'h0);
            end
            if (ack_o) begin
                lat  = k + 1;
                data = data_o;
            end else begin
                check({name, "_data_when_noack"}, data_o, 32'h0);
            end
        end
    endtask

    logic        a;
    logic [31:0] d;
    int          lat;

    initial begin
        svec[0] = '{1'b1, STAT,           32'h0,         1'b1, 32'h0};
        svec[1] = '{1'b1, STAT + 32'd4,   32'h0,         1'b1, 32'h0};
        svec[2] = '{1'b1, STAT + 32'd8,   32'h0,         1'b0, 32'h0};
        svec[3] = '{1'b1, 32'h0000_2108,  32'h0,         1'b0, 32'h0};
        svec[4] = '{1'b1, 32'h0000_3008,  32'h0,         1'b0, 32'h0};
        svec[5] = '{1'b0, STAT + 32'd4,   32'hFFFF_FFFF, 1'b1, 32'h0};
        svec[6] = '{1'b0, STAT,           32'h0001_0003, 1'b1, 32'h0};
        svec[7] = '{1'b1, STAT + 32'd4,   32'h0,         1'b1, 32'h0};

        wvec[0] = '{1'b1, 32'h0000_2008, 32'h0,         3,  32'h1234_5678, 32'h0000_2008, 32'h1234_5678, 4};
        wvec[1] = '{1'b0, 32'h0000_20F0, 32'hA5A5_0001, 0,  32'hFFFF_FFFF, 32'h0000_20F0, 32'hFFFF_FFFF, 1};
        wvec[2] = '{1'b1, 32'h0000_2044, 32'h0,         16, 32'h0BAD_F00D, 32'h0000_2044, 32'h0BAD_F00D, 17};
        wvec[3] = '{1'b1, 32'h0000_2010, 32'h0,         15, 32'h5555_AAAA, 32'h0000_2010, 32'h5555_AAAA, 16};
        wvec[4] = '{1'b1, 32'h0000_2020, 32'h0,         -1, 32'h0,         32'h0000_2020, 32'hDEAD_BEEF, 17};

        // Reset state
        repeat (3) tick();
        check("rst_ack",      32'(ack_o), 32'h0);
        check("rst_data",     data_o, 32'h0);
        check("rst_irq",      32'(irq_o), 32'h0);
        check("rst_sub_req",  32'(sub_req_o), 32'h0);
        check("rst_sub_rstl", 32'(sub_rstl_o), 32'h0);
        reset = 1'b0;
        tick();
        check("run_sub_rstl", 32'(sub_rstl_o), 32'h1);
        up_startup = 1'b1;
        #1;
        check("startup_pass", 32'(sub_start_o), 32'h1);
        up_startup = 1'b0;

        for (int i = 0; i < 8; i++) begin
            single(svec[i].rd, svec[i].addr, svec[i].wdata, a, d);
            check($sformatf("stat%0d_ack", i), 32'(a), 32'(svec[i].exp_ack));
            check($sformatf("stat%0d_data", i), d, svec[i].exp_data);
            check($sformatf("stat%0d_no_sub_req", i), 32'(sub_req_o), 32'h0);
            tick();
            check($sformatf("stat%0d_ack_pulse", i), 32'(ack_o), 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            window_txn($sformatf("win%0d", i), wvec[i].rd, wvec[i].addr, wvec[i].wdata,
                       wvec[i].ack_at, wvec[i].rdata, wvec[i].exp_sub_addr, lat, d);
            check($sformatf("win%0d_latency", i), 32'(lat), 32'(wvec[i].exp_lat));
            check($sformatf("win%0d_data", i), d, wvec[i].exp_data);
            tick();
        end

        // One timeout recorded so far
        check("to_irq", 32'(irq_o), 32'h1);
        single(1'b1, STAT, 32'h0, a, d);
        check("to_stat", d, 32'h0001_0001);
        tick();
        single(1'b1, STAT + 32'd4, 32'h0, a, d);
        check("to_last_addr", d, 32'h0000_2020);
        tick();

        // Late sub ack after a timed-out write is discarded
        window_txn("late", 1'b0, 32'h0000_2040, 32'h7777_0000, -1, 32'h0, 32'h0000_2040, lat, d);
        check("late_to_latency", 32'(lat), 32'd17);
        check("late_to_wr_data", d, 32'h0);
        repeat (4) tick();
        sub_ack = 1'b1; sub_rdata = 32'h9999_9999;
        tick();
        sub_ack = 1'b0; sub_rdata = 32'h0;
        check("late_ack_dropped", 32'(ack_o), 32'h0);
        tick();
        check("late_ack_dropped2", 32'(ack_o), 32'h0);
        window_txn("after_late", 1'b1, 32'h0000_20C4, 32'h0, 2, 32'h0102_0304, 32'h0000_20C4, lat, d);
        check("after_late_latency", 32'(lat), 32'd3);
        check("after_late_data", d, 32'h0102_0304);
        tick();

        // Requests while BUSY are dropped and flag a protocol error
        up_req = 1'b1; up_rd = 1'b1; up_addr = 32'h0000_2050;
        tick();
        up_req = 1'b0; up_rd = 1'b0; up_addr = 32'h0;
        check("proto_sub_req", 32'(sub_req_o), 32'h1);
        tick();
        single(1'b1, 32'h0000_2060, 32'h0, a, d);
        check("proto_win_drop_ack", 32'(a), 32'h0);
        check("proto_win_drop_sub", 32'(sub_req_o), 32'h0);
        single(1'b1, STAT, 32'h0, a, d);
        check("proto_stat_drop_ack", 32'(a), 32'h0);
        sub_ack = 1'b1; sub_rdata = 32'hCAFE_0001;
        tick();
        sub_ack = 1'b0; sub_rdata = 32'h0;
        check("proto_ack", 32'(ack_o), 32'h1);
        check("proto_data", data_o, 32'hCAFE_0001);
        check("proto_irq", 32'(irq_o), 32'h1);
        tick();
        single(1'b1, STAT, 32'h0, a, d);
        check("proto_stat", d, 32'h0002_0003);
        tick();
        single(1'b0, STAT, 32'h0001_0003, a, d);
        check("clr_ack", 32'(a), 32'h1);
        check("clr_wr_data", d, 32'h0);
        tick();
        single(1'b1, STAT, 32'h0, a, d);
        check("clr_stat", d, 32'h0);
        check("clr_irq", 32'(irq_o), 32'h0);
        tick();
        sub_irq = 1'b1;
        #1;
        check("sub_irq_pass", 32'(irq_o), 32'h1);
        sub_irq = 1'b0;

        // Reset in the middle of a transaction
        up_req = 1'b1; up_rd = 1'b1; up_addr = 32'h0000_2070;
        tick();
        up_req = 1'b0; up_rd = 1'b0; up_addr = 32'h0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ack", 32'(ack_o), 32'h0);
        check("mid_rst_sub_req", 32'(sub_req_o), 32'h0);
        sub_ack = 1'b1; sub_rdata = 32'h1111_1111;
        tick();
        sub_ack = 1'b0; sub_rdata = 32'h0;
        check("post_rst_ack_dropped", 32'(ack_o), 32'h0);
        tick();
        check("post_rst_ack_dropped2", 32'(ack_o), 32'h0);
        single(1'b1, STAT, 32'h0, a, d);
        check("post_rst_stat_ack", 32'(a), 32'h1);
        check("post_rst_stat", d, 32'h0);
        tick();
        single(1'b1, STAT + 32'd4, 32'h0, a, d);
        check("post_rst_last_addr", d, 32'h0);
        check("post_rst_irq", 32'(irq_o), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
